// File: rtl/alu_nibble_seq_if.sv
// Requester and slice-chain signals of the two-pass nibble ALU sequencer.
// master = requester plus slice chain (drives the inputs), slave = the sequencer.
interface alu_nibble_seq_if;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       cf_in;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       result_we;
  logic       cf;
  logic       hf;
  logic       zf;
  logic       sf;
  logic       pvf;
  logic [3:0] alu_op1;
  logic [3:0] alu_op2;
  logic       alu_cy_in;
  logic       alu_R;
  logic       alu_S;
  logic       alu_V;
  logic [3:0] alu_result;
  logic       alu_cy_out;

  modport master (
    output start, op, a, b, cf_in, alu_result, alu_cy_out,
    input  busy, done, result, result_we, cf, hf, zf, sf, pvf,
           alu_op1, alu_op2, alu_cy_in, alu_R, alu_S, alu_V
  );

  modport slave (
    input  start, op, a, b, cf_in, alu_result, alu_cy_out,
    output busy, done, result, result_we, cf, hf, zf, sf, pvf,
           alu_op1, alu_op2, alu_cy_in, alu_R, alu_S, alu_V
  );
endinterface

// File: rtl/alu_nibble_seq.sv
// Runs one 8-bit ALU op as low then high nibble passes through the 4-bit slice chain.
// Latency: done 3 cycles after accepted start; start is ignored while busy (no queueing).
module alu_nibble_seq #(
  parameter bit HOLD_OPERANDS = 1'b1,
  parameter bit AND_SETS_H    = 1'b1
) (
  input logic             clk,
  input logic             nreset,
  alu_nibble_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_CP  = 3'b111;

  logic [1:0] state;

  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [2:0] op_q;
  logic       cf_q;

  logic [7:0] a_e;
  logic [7:0] b_e;
  logic [2:0] op_e;
  logic       cf_e;

  logic [3:0] lo_nib;
  logic       c4;
  logic       we_q;
  logic [7:0] result_q;
  logic       cf_q_out;
  logic       hf_q;
  logic       zf_q;
  logic       sf_q;
  logic       pvf_q;

  logic       is_logic;
  logic       is_sub;
  logic       is_and;
  logic [7:0] op2p;
  logic       ctl_r;
  logic       ctl_s;
  logic       ctl_v;
  logic       lo_cy;

  logic [7:0] res_nxt;
  logic       cf_nxt;
  logic       hf_nxt;
  logic       pvf_nxt;

  // Operand source: the accept-time snapshot, or the live bus when the requester holds it.
  always_comb begin
    if (HOLD_OPERANDS) begin
      a_e  = a_q;
      b_e  = b_q;
      op_e = op_q;
      cf_e = cf_q;
    end else begin
      a_e  = bus.a;
      b_e  = bus.b;
      op_e = bus.op;
      cf_e = bus.cf_in;
    end
  end

  always_comb begin
    is_logic = 1'b0;
    is_sub   = 1'b0;
    is_and   = 1'b0;
    ctl_r    = 1'b0;
    ctl_s    = 1'b0;
    ctl_v    = 1'b0;
    lo_cy    = 1'b0;
    case (op_e)
      OP_ADD: lo_cy = 1'b0;
      OP_ADC: lo_cy = cf_e;
      OP_SUB: begin
        is_sub = 1'b1;
        lo_cy  = 1'b1;
      end
      OP_SBC: begin
        is_sub = 1'b1;
        lo_cy  = ~cf_e;
      end
      OP_CP: begin
        is_sub = 1'b1;
        lo_cy  = 1'b1;
      end
      OP_AND: begin
        is_logic = 1'b1;
        is_and   = 1'b1;
        ctl_s    = 1'b1;
        lo_cy    = 1'b1;
      end
      OP_XOR: begin
        is_logic = 1'b1;
        ctl_r    = 1'b1;
      end
      OP_OR: begin
        is_logic = 1'b1;
        ctl_r    = 1'b1;
        ctl_s    = 1'b1;
        ctl_v    = 1'b1;
      end
      default: ;
    endcase
  end

  // Subtraction is done as a + ~b + carry, so the inverted operand feeds the chain.
  assign op2p = is_sub ? ~b_e : b_e;

  always_comb begin
    bus.alu_op1   = 4'h0;
    bus.alu_op2   = 4'h0;
    bus.alu_cy_in = 1'b0;
    bus.alu_R     = 1'b0;
    bus.alu_S     = 1'b0;
    bus.alu_V     = 1'b0;
    case (state)
      ST_LO: begin
        bus.alu_op1   = a_e[3:0];
        bus.alu_op2   = op2p[3:0];
        bus.alu_cy_in = lo_cy;
        bus.alu_R     = ctl_r;
        bus.alu_S     = ctl_s;
        bus.alu_V     = ctl_v;
      end
      ST_HI: begin
        bus.alu_op1   = a_e[7:4];
        bus.alu_op2   = op2p[7:4];
        bus.alu_cy_in = is_logic ? is_and : c4;
        bus.alu_R     = ctl_r;
        bus.alu_S     = ctl_s;
        bus.alu_V     = ctl_v;
      end
      default: ;
    endcase
  end

  assign res_nxt = {bus.alu_result, lo_nib};

  // Borrow sense is the inverse of the chain carry for the subtract family.
  always_comb begin
    if (is_logic) begin
      cf_nxt  = 1'b0;
      hf_nxt  = is_and & AND_SETS_H;
      pvf_nxt = ~^res_nxt;
    end else begin
      cf_nxt  = bus.alu_cy_out ^ is_sub;
      hf_nxt  = c4 ^ is_sub;
      pvf_nxt = (a_e[7] == op2p[7]) & (res_nxt[7] != a_e[7]);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= ST_IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      op_q     <= 3'b000;
      cf_q     <= 1'b0;
      lo_nib   <= 4'h0;
      c4       <= 1'b0;
      we_q     <= 1'b0;
      result_q <= 8'h00;
      cf_q_out <= 1'b0;
      hf_q     <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      pvf_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state <= ST_LO;
            a_q   <= bus.a;
            b_q   <= bus.b;
            op_q  <= bus.op;
            cf_q  <= bus.cf_in;
          end
        end
        ST_LO: begin
          // Low nibble kept internally so the visible result only changes at completion.
          lo_nib <= bus.alu_result;
          c4     <= bus.alu_cy_out;
          state  <= ST_HI;
        end
        ST_HI: begin
          result_q <= res_nxt;
          cf_q_out <= cf_nxt;
          hf_q     <= hf_nxt;
          zf_q     <= (res_nxt == 8'h00);
          sf_q     <= res_nxt[7];
          pvf_q    <= pvf_nxt;
          we_q     <= (op_e != OP_CP);
          state    <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.result_we = (state == ST_DONE) & we_q;
  assign bus.result    = result_q;
  assign bus.cf        = cf_q_out;
  assign bus.hf        = hf_q;
  assign bus.zf        = zf_q;
  assign bus.sf        = sf_q;
  assign bus.pvf       = pvf_q;

endmodule
